dreg_wr_arbiter: RTL and testbench



---
 rtl/dreg_wr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dreg_wr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dreg_wr_arbiter.sv
// Round-robin write arbiter that shares one load/en/d data register between N producers.
// The winner's data is latched at grant, held until an enabled edge commits it, then acked.
module dreg_wr_arbiter #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic           clk50m,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   ack,
    output logic           reg_load,
    output logic [W-1:0]   reg_d,
    output logic           busy
);

    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW1 = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   r_win;
    logic [PW-1:0]   w_win_nxt;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    w_grant_nxt;
    logic [N-1:0]    r_ack;
    logic [N-1:0]    w_ack_nxt;
    logic            r_reg_load;
    logic            w_reg_load_nxt;
    logic [W-1:0]    r_reg_d;
    logic [W-1:0]    w_reg_d_nxt;
    logic            r_busy;
    logic            w_busy_nxt;

    logic [PW-1:0]   w_pick;
    logic [N-1:0]    w_pick_onehot;
    logic [W-1:0]    w_pick_data;

    // First requester at or after ptr, searching upward modulo N.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req_v,
                                              input logic [PW-1:0] ptr_v);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx;
        logic [PW1-1:0] sum;
        logic           found;
        pick  = ptr_v;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_v} + PW1'(i);
            if (sum >= PW1'(N)) begin
                sum = sum - PW1'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req_v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_pick        = rr_pick(req, r_ptr);
    assign w_pick_onehot = {{(N-1){1'b0}}, 1'b1} << w_pick;

    // Data mux for the arbitration winner's slice.
    always_comb begin
        w_pick_data = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (w_pick == PW'(i)) begin
                w_pick_data = wdata[i*W +: W];
            end else begin
                w_pick_data = w_pick_data;
            end
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_win_nxt      = r_win;
        w_grant_nxt    = r_grant;
        w_ack_nxt      = r_ack;
        w_reg_load_nxt = r_reg_load;
        w_reg_d_nxt    = r_reg_d;
        w_busy_nxt     = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt    = ST_LOAD;
                    w_win_nxt      = w_pick;
                    w_grant_nxt    = w_pick_onehot;
                    w_reg_d_nxt    = w_pick_data;
                    w_reg_load_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_busy_nxt     = 1'b0;
                end
            end
            ST_LOAD: begin
                // The shared register captures on this same edge, so ack follows commit.
                if (en) begin
                    w_state_nxt    = ST_ACK;
                    w_reg_load_nxt = 1'b0;
                    w_grant_nxt    = {N{1'b0}};
                    w_ack_nxt      = r_grant;
                    w_ptr_nxt      = (r_win == PW'(N-1)) ? {PW{1'b0}} : r_win + PW'(1);
                end else begin
                    w_state_nxt    = ST_LOAD;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                w_ack_nxt   = {N{1'b0}};
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_grant_nxt    = {N{1'b0}};
                w_ack_nxt      = {N{1'b0}};
                w_reg_load_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= {PW{1'b0}};
            r_win      <= {PW{1'b0}};
            r_grant    <= {N{1'b0}};
            r_ack      <= {N{1'b0}};
            r_reg_load <= 1'b0;
            r_reg_d    <= {W{1'b0}};
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_win      <= w_win_nxt;
            r_grant    <= w_grant_nxt;
            r_ack      <= w_ack_nxt;
            r_reg_load <= w_reg_load_nxt;
            r_reg_d    <= w_reg_d_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign grant    = r_grant;
    assign ack      = r_ack;
    assign reg_load = r_reg_load;
    assign reg_d    = r_reg_d;
    assign busy     = r_busy;

endmodule

// File: tb/tb_dreg_wr_arbiter.sv
// Directed bench for dreg_wr_arbiter with a behavioural copy of the shared register.
module tb_dreg_wr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk50m = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           reg_load;
    logic [W-1:0]   reg_d;
    logic           busy;
    logic [W-1:0]   q_model;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] rr_data [N];
    logic [N-1:0] exp_oh;
    int           w;

    always #10 clk50m = ~clk50m;

    dreg_wr_arbiter #(.N(N), .W(W)) u_dut (
        .clk50m  (clk50m),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .wdata   (wdata),
        .grant   (grant),
        .ack     (ack),
        .reg_load(reg_load),
        .reg_d   (reg_d),
        .busy    (busy)
    );

    // Shared data register fed by the arbiter.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            q_model <= {W{1'b0}};
        end else if (reg_load && en) begin
            q_model <= reg_d;
        end else begin
            q_model <= q_model;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk50m);
        #1;
    endtask

    task automatic set_slice(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b0000;
        wdata = {(N*W){1'b0}};
        rr_data[0] = 16'hA000;
        rr_data[1] = 16'hA111;
        rr_data[2] = 16'hA222;
        rr_data[3] = 16'hA333;

        // Reset state
        tick;
        tick;
        check_val("rst_grant", 32'(grant), 32'h0);
        check_val("rst_ack", 32'(ack), 32'h0);
        check_val("rst_load", 32'(reg_load), 32'h0);
        check_val("rst_d", 32'(reg_d), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick;

        // Single write
        set_slice(0, 16'hBEEF);
        req = 4'b0001;
        tick;
        check_val("single_grant", 32'(grant), 32'h1);
        check_val("single_load", 32'(reg_load), 32'h1);
        check_val("single_d", 32'(reg_d), 32'hBEEF);
        check_val("single_busy", 32'(busy), 32'h1);
        tick;
        check_val("single_ack", 32'(ack), 32'h1);
        check_val("single_q", 32'(q_model), 32'hBEEF);
        check_val("single_load_off", 32'(reg_load), 32'h0);
        check_val("single_grant_off", 32'(grant), 32'h0);
        req = 4'b0000;
        tick;
        check_val("single_busy_off", 32'(busy), 32'h0);
        check_val("single_ack_off", 32'(ack), 32'h0);

        // Round-robin from ptr=0
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < N; i++) begin
            set_slice(i, rr_data[i]);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = k % N;
            exp_oh = 4'b0001 << w;
            tick;
            check_val($sformatf("rr%0d_grant", k), 32'(grant), 32'(exp_oh));
            check_val($sformatf("rr%0d_d", k), 32'(reg_d), 32'(rr_data[w]));
            tick;
            check_val($sformatf("rr%0d_ack", k), 32'(ack), 32'(exp_oh));
            check_val($sformatf("rr%0d_q", k), 32'(q_model), 32'(rr_data[w]));
            req[w] = 1'b0;
            tick;
            check_val($sformatf("rr%0d_idle", k), 32'(busy), 32'h0);
            req[w] = 1'b1;
        end
        req = 4'b0000;

        // en stall with requester 2 (ptr=1)
        en = 1'b0;
        set_slice(2, 16'h1234);
        req = 4'b0100;
        tick;
        check_val("stall_grant", 32'(grant), 32'h4);
        check_val("stall_load", 32'(reg_load), 32'h1);
        check_val("stall_d", 32'(reg_d), 32'h1234);
        for (int c = 0; c < 5; c++) begin
            tick;
            check_val($sformatf("stall%0d_load", c), 32'(reg_load), 32'h1);
            check_val($sformatf("stall%0d_d", c), 32'(reg_d), 32'h1234);
            check_val($sformatf("stall%0d_ack", c), 32'(ack), 32'h0);
            check_val($sformatf("stall%0d_q", c), 32'(q_model), 32'hA000);
        end
        en = 1'b1;
        tick;
        check_val("stall_ack", 32'(ack), 32'h4);
        check_val("stall_q", 32'(q_model), 32'h1234);
        req = 4'b0000;
        tick;
        check_val("stall_idle", 32'(busy), 32'h0);

        // Data change and req drop during LOAD (ptr=3)
        en = 1'b0;
        set_slice(1, 16'h0001);
        req = 4'b0010;
        tick;
        check_val("abort_grant", 32'(grant), 32'h2);
        check_val("abort_d0", 32'(reg_d), 32'h0001);
        set_slice(1, 16'hFFFF);
        req = 4'b0000;
        tick;
        check_val("abort_d1", 32'(reg_d), 32'h0001);
        check_val("abort_load", 32'(reg_load), 32'h1);
        en = 1'b1;
        tick;
        check_val("abort_ack", 32'(ack), 32'h2);
        check_val("abort_q", 32'(q_model), 32'h0001);
        tick;
        check_val("abort_idle", 32'(busy), 32'h0);

        // Bring ptr to 3 via requester 2, then contend 0 vs 2
        set_slice(2, 16'h2222);
        req = 4'b0100;
        tick;
        check_val("pre_grant", 32'(grant), 32'h4);
        tick;
        req = 4'b0000;
        tick;
        set_slice(0, 16'h0A0A);
        set_slice(2, 16'h2C2C);
        req = 4'b0101;
        tick;
        check_val("wrap_grant0", 32'(grant), 32'h1);
        check_val("wrap_d0", 32'(reg_d), 32'h0A0A);
        tick;
        check_val("wrap_ack0", 32'(ack), 32'h1);
        check_val("wrap_q0", 32'(q_model), 32'h0A0A);
        req = 4'b0100;
        tick;
        tick;
        check_val("wrap_grant2", 32'(grant), 32'h4);
        check_val("wrap_d2", 32'(reg_d), 32'h2C2C);
        tick;
        check_val("wrap_ack2", 32'(ack), 32'h4);
        req = 4'b0000;
        tick;

        // Asynchronous reset in the middle of a stalled LOAD (ptr=3)
        en = 1'b0;
        set_slice(1, 16'h5555);
        req = 4'b0010;
        tick;
        check_val("mid_load", 32'(reg_load), 32'h1);
        #4;
        rst_n = 1'b0;
        #1;
        check_val("mid_load_off", 32'(reg_load), 32'h0);
        check_val("mid_grant_off", 32'(grant), 32'h0);
        check_val("mid_busy_off", 32'(busy), 32'h0);
        check_val("mid_q", 32'(q_model), 32'h0);
        req = 4'b0000;
        en  = 1'b1;
        tick;
        rst_n = 1'b1;
        tick;
        check_val("post_ack", 32'(ack), 32'h0);
        check_val("post_busy", 32'(busy), 32'h0);
        set_slice(1, 16'h1111);
        set_slice(3, 16'h3333);
        req = 4'b1010;
        tick;
        check_val("post_ptr_grant", 32'(grant), 32'h2);
        tick;
        check_val("post_ack1", 32'(ack), 32'h2);
        check_val("post_q", 32'(q_model), 32'h1111);
        req = 4'b0000;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
